// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Bundles every signal the load/store unit exchanges with its surroundings:
//   the CPU request/response handshake and the data memory ports.
//
//   modport slave  : the load/store unit itself (takes requests, drives memory)
//   modport master : the environment (execute stage issuing requests plus the
//                    data memory returning mem_read_value)
//
//   Request  : req_valid, req_ready, req_write, req_size, req_unsigned,
//              req_address, req_wdata
//   Response : resp_valid, resp_rdata, resp_misaligned, resp_out_of_range
//   Memory   : mem_read_enable, mem_read_address, mem_read_value,
//              mem_write_enable, mem_write_address, mem_write_value
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_out_of_range;

    logic        mem_read_enable;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_value;
    logic        mem_write_enable;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_value;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_misaligned, resp_out_of_range,
        input  mem_read_enable, mem_read_address,
        input  mem_write_enable, mem_write_address, mem_write_value,
        output mem_read_value
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_misaligned, resp_out_of_range,
        output mem_read_enable, mem_read_address,
        output mem_write_enable, mem_write_address, mem_write_value,
        input  mem_read_value
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the word-organised data memory. Accepts one load/store
//   at a time (byte / half / word, signed or unsigned loads), drives the
//   memory's registered read port and full-word write port, and performs
//   sub-word stores as read-modify-write.
//
//   Ports:
//     clock   : system clock, rising edge
//     reset_n : synchronous active-low reset
//     bus     : load_store_unit_if.slave (request, response, memory ports)
//
//   Latencies from the acceptance cycle T:
//     error       -> response at T+1 (no memory access)
//     word store  -> write at T+1, response at T+2
//     load        -> read at T+1, response at T+3
//     sub-store   -> read at T+1, write at T+3, response at T+4
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned MEMORY_SIZE_BYTES = 4096
) (
    input  logic               clock,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q;

    // Captured request fields
    logic        write_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    // Registered outputs
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_misaligned_q;
    logic        resp_out_of_range_q;
    logic        mem_read_enable_q;
    logic [31:0] mem_read_address_q;
    logic        mem_write_enable_q;
    logic [31:0] mem_write_address_q;
    logic [31:0] mem_write_value_q;

    // Combinational helpers
    logic        misaligned_d;
    logic        out_of_range_d;
    logic [4:0]  lane_shift;
    logic [31:0] shifted_read;
    logic [31:0] lane_mask;
    logic [31:0] load_data_d;
    logic [31:0] merge_data_d;

    always_comb begin
        misaligned_d   = (bus.req_size == 2'b11)
                       | ((bus.req_size == 2'b01) & bus.req_address[0])
                       | ((bus.req_size == 2'b10) & (bus.req_address[1:0] != 2'b00));
        out_of_range_d = (bus.req_address >= 32'(MEMORY_SIZE_BYTES));

        // Little-endian lanes: the addressed byte sits at bit 8*lane.
        lane_shift   = {lane_q, 3'b000};
        shifted_read = bus.mem_read_value >> lane_shift;

        load_data_d = shifted_read;
        case (size_q)
            2'b00:   load_data_d = unsigned_q ? {24'd0, shifted_read[7:0]}
                                              : {{24{shifted_read[7]}}, shifted_read[7:0]};
            2'b01:   load_data_d = unsigned_q ? {16'd0, shifted_read[15:0]}
                                              : {{16{shifted_read[15]}}, shifted_read[15:0]};
            default: load_data_d = shifted_read;
        endcase

        lane_mask    = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
        merge_data_d = (bus.mem_read_value & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q             <= S_IDLE;
            write_q             <= 1'b0;
            unsigned_q          <= 1'b0;
            size_q              <= 2'b00;
            lane_q              <= 2'b00;
            wdata_q             <= 32'd0;
            req_ready_q         <= 1'b1;
            resp_valid_q        <= 1'b0;
            resp_rdata_q        <= 32'd0;
            resp_misaligned_q   <= 1'b0;
            resp_out_of_range_q <= 1'b0;
            mem_read_enable_q   <= 1'b0;
            mem_read_address_q  <= 32'd0;
            mem_write_enable_q  <= 1'b0;
            mem_write_address_q <= 32'd0;
            mem_write_value_q   <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        write_q     <= bus.req_write;
                        unsigned_q  <= bus.req_unsigned;
                        size_q      <= bus.req_size;
                        lane_q      <= bus.req_address[1:0];
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (misaligned_d || out_of_range_d) begin
                            // Misalignment takes priority over range.
                            resp_valid_q        <= 1'b1;
                            resp_rdata_q        <= 32'd0;
                            resp_misaligned_q   <= misaligned_d;
                            resp_out_of_range_q <= ~misaligned_d & out_of_range_d;
                            state_q             <= S_DONE;
                        end else begin
                            mem_read_address_q <= {bus.req_address[31:2], 2'b00};
                            if (bus.req_write) begin
                                mem_write_address_q <= {bus.req_address[31:2], 2'b00};
                            end
                            if (bus.req_write && (bus.req_size == 2'b10)) begin
                                mem_write_enable_q <= 1'b1;
                                mem_write_value_q  <= bus.req_wdata;
                                state_q            <= S_WRITE;
                            end else begin
                                mem_read_enable_q <= 1'b1;
                                state_q           <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    // Memory data shows up one cycle later, in MERGE.
                    mem_read_enable_q <= 1'b0;
                    state_q           <= S_MERGE;
                end
                S_MERGE: begin
                    if (write_q) begin
                        mem_write_value_q  <= merge_data_d;
                        mem_write_enable_q <= 1'b1;
                        state_q            <= S_WRITE;
                    end else begin
                        resp_rdata_q <= load_data_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_WRITE: begin
                    mem_write_enable_q <= 1'b0;
                    resp_rdata_q       <= 32'd0;
                    resp_valid_q       <= 1'b1;
                    state_q            <= S_DONE;
                end
                S_DONE: begin
                    resp_valid_q        <= 1'b0;
                    resp_misaligned_q   <= 1'b0;
                    resp_out_of_range_q <= 1'b0;
                    req_ready_q         <= 1'b1;
                    state_q             <= S_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready         = req_ready_q;
    assign bus.resp_valid        = resp_valid_q;
    assign bus.resp_rdata        = resp_rdata_q;
    assign bus.resp_misaligned   = resp_misaligned_q;
    assign bus.resp_out_of_range = resp_out_of_range_q;
    assign bus.mem_read_enable   = mem_read_enable_q;
    assign bus.mem_read_address  = mem_read_address_q;
    assign bus.mem_write_address = mem_write_address_q;
    assign bus.mem_write_value   = mem_write_value_q;
    // The write strobe is qualified by reset_n so a reset arriving while in
    // WRITE suppresses the write at that very edge, not just the cycle after.
    assign bus.mem_write_enable  = mem_write_enable_q & reset_n;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    load_store_unit_if bus ();

    load_store_unit #(.MEMORY_SIZE_BYTES(4096)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory model: registered read, full-word write.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;
    always @(posedge clock) begin
        if (bus.mem_read_enable)  rd_q <= mem[bus.mem_read_address[11:2]];
        if (bus.mem_write_enable) mem[bus.mem_write_address[11:2]] <= bus.mem_write_value;
    end
    assign bus.mem_read_value = rd_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and check everything seen until the response.
    task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rdata,
                           input logic exp_mis, input logic exp_oor,
                           input int exp_reads, input int exp_writes,
                           input logic [31:0] exp_wval);
        int waited, lat, reads, writes, rd_k, wr_k;
        logic [31:0] raddr, waddr, wval, rdata;
        logic mis, oor;
        waited = 0; lat = 0; reads = 0; writes = 0; rd_k = 0; wr_k = 0;
        raddr = '0; waddr = '0; wval = '0; rdata = '0; mis = 1'b0; oor = 1'b0;
        @(negedge clock);
        while (!bus.req_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_address  = addr;
        bus.req_wdata    = wd;
        @(negedge clock);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clock);
            if (bus.mem_read_enable) begin
                reads++; raddr = bus.mem_read_address; rd_k = k;
            end
            if (bus.mem_write_enable) begin
                writes++; waddr = bus.mem_write_address; wval = bus.mem_write_value; wr_k = k;
            end
            if (bus.resp_valid) begin
                lat = k; rdata = bus.resp_rdata;
                mis = bus.resp_misaligned; oor = bus.resp_out_of_range;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " misaligned"}, 32'(mis), 32'(exp_mis));
        check({tag, " out_of_range"}, 32'(oor), 32'(exp_oor));
        check({tag, " reads"}, 32'(reads), 32'(exp_reads));
        check({tag, " writes"}, 32'(writes), 32'(exp_writes));
        if (exp_reads > 0) begin
            check({tag, " read_addr"}, raddr, {addr[31:2], 2'b00});
            check({tag, " read_cycle"}, 32'(rd_k), 32'd1);
        end
        if (exp_writes > 0) begin
            check({tag, " write_addr"}, waddr, {addr[31:2], 2'b00});
            check({tag, " write_value"}, wval, exp_wval);
            check({tag, " write_cycle"}, 32'(wr_k), 32'(exp_lat - 1));
        end
        @(negedge clock);
        check({tag, " resp_pulse"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " ready_back"}, 32'(bus.req_ready), 32'd1);
        check({tag, " flags_clear"}, 32'({bus.resp_misaligned, bus.resp_out_of_range}), 32'd0);
        $display("txn %-14s addr=0x%08h lat=%0d rdata=0x%08h mis=%0b oor=%0b", tag, addr, lat, rdata, mis, oor);
    endtask

    initial begin
        int wen_cnt, idx, acc0, acc1, acc2, waited;
        logic acc_prev;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[32'h10 >> 2] = 32'h8000_00FF;
        mem[32'h20 >> 2] = 32'h1122_3344;
        rd_q = 32'd0;
        reset_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_address = 32'd0; bus.req_wdata = 32'd0;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst ready", 32'(bus.req_ready), 32'd1);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst strobes", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
        check("rst flags", 32'({bus.resp_misaligned, bus.resp_out_of_range}), 32'd0);
        check("rst rdata", bus.resp_rdata, 32'd0);
        check("rst read_addr", bus.mem_read_address, 32'd0);
        check("rst write_addr", bus.mem_write_address, 32'd0);
        check("rst write_value", bus.mem_write_value, 32'd0);
        reset_n = 1'b1;

        //      tag            wr  sz     uns   addr          wdata         lat rdata         mis  oor  rd wr wval
        run_req("ld_w 10",     0, 2'b10, 1'b0, 32'h10,   32'h0,         3, 32'h8000_00FF, 0, 0, 1, 0, 32'h0);
        run_req("ld_bs 13",    0, 2'b00, 1'b0, 32'h13,   32'h0,         3, 32'hFFFF_FF80, 0, 0, 1, 0, 32'h0);
        run_req("ld_bu 10",    0, 2'b00, 1'b1, 32'h10,   32'h0,         3, 32'h0000_00FF, 0, 0, 1, 0, 32'h0);
        run_req("ld_bs 10",    0, 2'b00, 1'b0, 32'h10,   32'h0,         3, 32'hFFFF_FFFF, 0, 0, 1, 0, 32'h0);
        run_req("ld_hs 12",    0, 2'b01, 1'b0, 32'h12,   32'h0,         3, 32'hFFFF_8000, 0, 0, 1, 0, 32'h0);
        run_req("ld_hu 12",    0, 2'b01, 1'b1, 32'h12,   32'h0,         3, 32'h0000_8000, 0, 0, 1, 0, 32'h0);
        run_req("st_h 22",     1, 2'b01, 1'b0, 32'h22,   32'h0000_ABCD, 4, 32'h0,         0, 0, 1, 1, 32'hABCD_3344);
        run_req("ld_w 20",     0, 2'b10, 1'b0, 32'h20,   32'h0,         3, 32'hABCD_3344, 0, 0, 1, 0, 32'h0);
        run_req("st_b 21",     1, 2'b00, 1'b0, 32'h21,   32'hFFFF_FF5A, 4, 32'h0,         0, 0, 1, 1, 32'hABCD_5A44);
        run_req("st_w 30",     1, 2'b10, 1'b0, 32'h30,   32'hDEAD_BEEF, 2, 32'h0,         0, 0, 0, 1, 32'hDEAD_BEEF);
        run_req("ld_w 30",     0, 2'b10, 1'b0, 32'h30,   32'h0,         3, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'h0);
        run_req("ld_bu FFF",   0, 2'b00, 1'b1, 32'hFFF,  32'h0,         3, 32'h0,         0, 0, 1, 0, 32'h0);
        run_req("err ld_w 06", 0, 2'b10, 1'b0, 32'h06,   32'h0,         1, 32'h0,         1, 0, 0, 0, 32'h0);
        run_req("err ld_b 1000",0,2'b00, 1'b0, 32'h1000, 32'h0,         1, 32'h0,         0, 1, 0, 0, 32'h0);
        run_req("err size11",  0, 2'b11, 1'b0, 32'h0,    32'h0,         1, 32'h0,         1, 0, 0, 0, 32'h0);
        run_req("err both",    1, 2'b10, 1'b0, 32'h1002, 32'h1,         1, 32'h0,         1, 0, 0, 0, 32'h0);
        run_req("err ld_h 01", 0, 2'b01, 1'b1, 32'h01,   32'h0,         1, 32'h0,         1, 0, 0, 0, 32'h0);

        // Back-to-back word stores with req_valid held high.
        b2b_addr[0] = 32'h40; b2b_addr[1] = 32'h44; b2b_addr[2] = 32'h48;
        b2b_data[0] = 32'h0101_0101; b2b_data[1] = 32'h0202_0202; b2b_data[2] = 32'h0303_0303;
        idx = 0; wen_cnt = 0; acc0 = -1; acc1 = -1; acc2 = -1; acc_prev = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_address = b2b_addr[0]; bus.req_wdata = b2b_data[0];
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clock);
            if (acc_prev) begin
                idx++;
                if (idx < 3) begin
                    bus.req_address = b2b_addr[idx]; bus.req_wdata = b2b_data[idx];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (bus.mem_write_enable) wen_cnt++;
            acc_prev = bus.req_ready && bus.req_valid;
            if (acc_prev) begin
                if (idx == 0) acc0 = c;
                else if (idx == 1) acc1 = c;
                else acc2 = c;
            end
        end
        bus.req_valid = 1'b0;
        check("b2b gap01", 32'(acc1 - acc0), 32'd3);
        check("b2b gap12", 32'(acc2 - acc1), 32'd3);
        check("b2b writes", 32'(wen_cnt), 32'd3);
        check("b2b mem40", mem[32'h40 >> 2], 32'h0101_0101);
        check("b2b mem44", mem[32'h44 >> 2], 32'h0202_0202);
        check("b2b mem48", mem[32'h48 >> 2], 32'h0303_0303);
        $display("txn b2b            acc=%0d,%0d,%0d writes=%0d", acc0, acc1, acc2, wen_cnt);

        // Reset during the WRITE cycle of a byte store.
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
        bus.req_address = 32'h51; bus.req_wdata = 32'h77;
        @(negedge clock);
        bus.req_valid = 1'b0;
        waited = 0;
        while (!bus.mem_write_enable && waited < 6) begin
            @(negedge clock);
            waited++;
        end
        check("rmid reached_write", 32'(bus.mem_write_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rmid wen_at_edge", 32'(bus.mem_write_enable), 32'd0);
        @(negedge clock);
        check("rmid ready", 32'(bus.req_ready), 32'd1);
        check("rmid strobes", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
        check("rmid resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rmid mem50", mem[32'h50 >> 2], 32'd0);
        reset_n = 1'b1;
        $display("txn reset_mid      addr=0x00000051");
        run_req("ld_w 50", 0, 2'b10, 1'b0, 32'h50, 32'h0, 3, 32'h0, 0, 0, 1, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
